// File: rtl/rr_arb4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb4
// Brief    : Four-requester round-robin arbiter with IDLE/GRANT sequencing.
//            Drives a registered 2-bit owner index and matching one-hot grant.
//            A grant is held while the owner keeps its request high and is
//            always followed by at least one idle (bubble) cycle.
// Options  : RR_ARB_TIMEOUT_EN - when defined, a grant held for MAX_HOLD
//            cycles is revoked and 'expire' pulses for one cycle.
//            When undefined, there is no hold counter and 'expire' is 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb4 #(
  parameter int MAX_HOLD = 15,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_vld,
  output logic       expire
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_grant = 1'b1;

  logic [0:0] r_st;
  logic [0:0] w_st_nxt;

  // Round-robin pointer: the requester searched first at the next arbitration
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;

  // Registered outputs and their next values
  logic [3:0] r_gnt;
  logic [1:0] r_gnt_id;
  logic       r_gnt_vld;
  logic       r_expire;
  logic [3:0] w_gnt_nxt;
  logic [1:0] w_gnt_id_nxt;
  logic       w_gnt_vld_nxt;
  logic       w_expire_nxt;

  // Arbitration helpers
  logic [3:0] w_rot;      // req rotated so that bit 0 is req[r_ptr]
  logic [1:0] w_off;      // offset of first set bit in w_rot
  logic       w_any;      // at least one request pending
  logic [1:0] w_winner;   // absolute index of the winning requester
  logic       w_own_req;  // current owner still requesting
  logic       w_release;  // owner dropped its request while granted
  logic       w_timeout;  // hold limit reached with request still high
  logic       w_revoke;   // grant ends on this edge for either reason

  // --------------------------------------------------------------------------
  // Reject hold limits that cannot be represented by the hold counter
  // --------------------------------------------------------------------------
  generate
    if ((MAX_HOLD < 2) || (MAX_HOLD > ((2 ** CW) - 1))) begin : g_bad_max_hold
      $error("rr_arb4: MAX_HOLD must lie in 2 .. 2**CW-1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Rotate the request vector so the search always starts at bit 0
  // --------------------------------------------------------------------------
  genvar j;
  generate
    for (j = 0; j < 4; j++) begin : g_rot
      assign w_rot[j] = req[r_ptr + 2'(j)];
    end
  endgenerate

  assign w_any = |req;

  // Fixed-priority search over the rotated vector, lowest offset wins
  always_comb begin
    w_off = 2'd0;
    if (w_rot[0]) begin
      w_off = 2'd0;
    end else if (w_rot[1]) begin
      w_off = 2'd1;
    end else if (w_rot[2]) begin
      w_off = 2'd2;
    end else if (w_rot[3]) begin
      w_off = 2'd3;
    end
  end

  // Offset back to absolute index; 2-bit addition wraps 3->0 naturally
  assign w_winner = r_ptr + w_off;

  // --------------------------------------------------------------------------
  // Grant termination conditions
  // --------------------------------------------------------------------------
  assign w_own_req = req[r_gnt_id];
  assign w_release = (r_st == c_st_grant) && !w_own_req;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [CW-1:0] c_hold_last = CW'(MAX_HOLD - 1);

  logic [CW-1:0] r_hcnt;

  // Hold counter: zero while idle so every grant starts counting from 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
    end else if (r_st == c_st_idle) begin
      r_hcnt <= '0;
    end else begin
      r_hcnt <= r_hcnt + CW'(1);
    end
  end

  // A drop on the limit edge is a normal release, so require the request high
  assign w_timeout = (r_st == c_st_grant) && w_own_req && (r_hcnt == c_hold_last);
`else
  assign w_timeout = 1'b0;
`endif

  assign w_revoke = w_release || w_timeout;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  // Hold current state; asynchronous reset returns to IDLE immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st <= c_st_idle;
    end else begin
      r_st <= w_st_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  // IDLE grants on any request; GRANT always returns to IDLE to force a bubble
  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      c_st_idle: begin
        if (w_any) begin
          w_st_nxt = c_st_grant;
        end
      end
      c_st_grant: begin
        if (w_revoke) begin
          w_st_nxt = c_st_idle;
        end
      end
      default: begin
        w_st_nxt = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM output logic (next values of the registered outputs)
  // --------------------------------------------------------------------------
  // Owner index changes only on a new grant; pointer advances past the owner
  // whenever its grant ends, whether released or revoked
  always_comb begin
    w_gnt_id_nxt  = r_gnt_id;
    w_gnt_vld_nxt = 1'b0;
    w_expire_nxt  = 1'b0;
    w_ptr_nxt     = r_ptr;
    case (r_st)
      c_st_idle: begin
        if (w_any) begin
          w_gnt_id_nxt  = w_winner;
          w_gnt_vld_nxt = 1'b1;
        end
      end
      c_st_grant: begin
        if (w_revoke) begin
          w_ptr_nxt    = r_gnt_id + 2'd1;
          w_expire_nxt = w_timeout;
        end else begin
          w_gnt_vld_nxt = 1'b1;
        end
      end
      default: begin
        w_gnt_vld_nxt = 1'b0;
      end
    endcase
  end

  // One-hot grant is a 2-to-4 decode of the next index, qualified by valid
  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_onehot
      assign w_gnt_nxt[i] = w_gnt_vld_nxt && (w_gnt_id_nxt == 2'(i));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output and pointer registers
  // --------------------------------------------------------------------------
  // Register every output so no combinational path exists from req
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= 2'd0;
      r_gnt     <= 4'b0000;
      r_gnt_id  <= 2'd0;
      r_gnt_vld <= 1'b0;
      r_expire  <= 1'b0;
    end else begin
      r_ptr     <= w_ptr_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_gnt_vld <= w_gnt_vld_nxt;
      r_expire  <= w_expire_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign gnt_vld = r_gnt_vld;
  assign expire  = r_expire;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb4
// Brief    : Directed self-checking bench for rr_arb4. Inputs change on the
//            falling edge; outputs are checked on the falling edge after the
//            rising edge that sampled them. Timeout steps are compiled when
//            RR_ARB_TIMEOUT_EN is defined; otherwise a long hold is checked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;
  logic       expire;

  int checks   = 0;
  int failures = 0;

  rr_arb4 #(
    .MAX_HOLD (4),
    .CW       (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .expire  (expire)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Compare {expire, gnt_vld, gnt_id, gnt} against hand-computed values
  task automatic expect_out(input string tag, input logic e_exp, input logic e_vld,
                            input logic [1:0] e_id, input logic [3:0] e_gnt);
    logic [7:0] obs;
    logic [7:0] exp_w;
    obs   = {expire, gnt_vld, gnt_id, gnt};
    exp_w = {e_exp, e_vld, e_id, e_gnt};
    checks++;
    assert (obs === exp_w) else begin
      failures++;
      $error("FAIL %s observed{exp,vld,id,gnt}=%b expected=%b", tag, obs, exp_w);
    end
  endtask

  initial begin
    logic [1:0] id;
    logic [3:0] oh;

    // Reset held with every requester active
    rst_n = 1'b0;
    req   = 4'b1111;
    tick();
    tick();
    expect_out("reset", 1'b0, 1'b0, 2'd0, 4'b0000);

    // First grant one edge after reset release goes to requester 0
    rst_n = 1'b1;
    tick();
    expect_out("rst_release", 1'b0, 1'b1, 2'd0, 4'b0001);

    // Rotation: own 3 cycles, drop for 1, expect 0,1,2,3,0 with bubbles
    for (int k = 0; k < 5; k++) begin
      id = 2'(k);
      oh = 4'b0001 << id;
      for (int h = 0; h < 2; h++) begin
        tick();
        expect_out("rot_hold", 1'b0, 1'b1, id, oh);
      end
      req = 4'b1111 & ~oh;
      tick();
      expect_out("rot_bubble", 1'b0, 1'b0, id, 4'b0000);
      if (k < 4) begin
        req = 4'b1111;
        tick();
        expect_out("rot_grant", 1'b0, 1'b1, id + 2'd1, oh == 4'b1000 ? 4'b0001 : oh << 1);
      end
    end

    // ptr=1 now; requester 2 wins, then release to leave ptr=3
    req = 4'b0100;
    tick();
    expect_out("grant2", 1'b0, 1'b1, 2'd2, 4'b0100);
    req = 4'b0000;
    tick();
    expect_out("rel2", 1'b0, 1'b0, 2'd2, 4'b0000);

    // Wrap: ptr=3, req 0101 -> search 3,0 -> 0
    req = 4'b0101;
    tick();
    expect_out("wrap", 1'b0, 1'b1, 2'd0, 4'b0001);
    req = 4'b0100;
    tick();
    expect_out("wrap_rel", 1'b0, 1'b0, 2'd0, 4'b0000);

    // Skip: ptr=1, req 0101 -> search 1,2 -> 2
    req = 4'b0101;
    tick();
    expect_out("skip", 1'b0, 1'b1, 2'd2, 4'b0100);
    req = 4'b0001;
    tick();
    expect_out("skip_rel", 1'b0, 1'b0, 2'd2, 4'b0000);

    // No requests: stay idle, index keeps last owner
    req = 4'b0000;
    tick();
    expect_out("idle_empty", 1'b0, 1'b0, 2'd2, 4'b0000);

    // Owner 1 holding, then asynchronous reset mid-grant
    req = 4'b0010;
    tick();
    expect_out("grant1", 1'b0, 1'b1, 2'd1, 4'b0010);
    tick();
    expect_out("hold1", 1'b0, 1'b1, 2'd1, 4'b0010);
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 1'b0, 2'd0, 4'b0000);
    tick();
    expect_out("rst_held", 1'b0, 1'b0, 2'd0, 4'b0000);

    // Pointer back to 0: req 0110 -> 1
    rst_n = 1'b1;
    req   = 4'b0110;
    tick();
    expect_out("post_rst_ptr", 1'b0, 1'b1, 2'd1, 4'b0010);
    req = 4'b0000;
    tick();
    expect_out("post_rst_rel", 1'b0, 1'b0, 2'd1, 4'b0000);

    // Single requester toggling every cycle alternates grant and bubble
    for (int t = 0; t < 3; t++) begin
      req = 4'b1000;
      tick();
      expect_out("toggle_gnt", 1'b0, 1'b1, 2'd3, 4'b1000);
      req = 4'b0000;
      tick();
      expect_out("toggle_bub", 1'b0, 1'b0, 2'd3, 4'b0000);
    end

`ifdef RR_ARB_TIMEOUT_EN
    // ptr=0; req 0001 held -> 4 grant cycles, expire bubble, regrant 0
    req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_out("to_hold0", 1'b0, 1'b1, 2'd0, 4'b0001);
    end
    tick();
    expect_out("to_expire0", 1'b1, 1'b0, 2'd0, 4'b0000);
    tick();
    expect_out("to_regrant0", 1'b0, 1'b1, 2'd0, 4'b0001);

    // req 0011: grant 0 times out, ptr=1 -> regrant to 1
    req = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_out("to_hold0b", 1'b0, 1'b1, 2'd0, 4'b0001);
    end
    tick();
    expect_out("to_expire0b", 1'b1, 1'b0, 2'd0, 4'b0000);
    tick();
    expect_out("to_regrant1", 1'b0, 1'b1, 2'd1, 4'b0010);

    // Owner 1 drops on the limit edge: normal release, no expire
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_out("to_hold1", 1'b0, 1'b1, 2'd1, 4'b0010);
    end
    req = 4'b0001;
    tick();
    expect_out("to_boundary", 1'b0, 1'b0, 2'd1, 4'b0000);
    tick();
    expect_out("to_after_bnd", 1'b0, 1'b1, 2'd0, 4'b0001);
    req = 4'b0000;
    tick();
    expect_out("to_final_rel", 1'b0, 1'b0, 2'd0, 4'b0000);
`else
    // ptr=0; req 0001 held 100 cycles: grant never revoked, expire stays 0
    req = 4'b0001;
    tick();
    expect_out("long_grant", 1'b0, 1'b1, 2'd0, 4'b0001);
    for (int c = 0; c < 100; c++) begin
      tick();
      expect_out("long_hold", 1'b0, 1'b1, 2'd0, 4'b0001);
    end
    req = 4'b0000;
    tick();
    expect_out("long_rel", 1'b0, 1'b0, 2'd0, 4'b0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
